// File: rtl/display_arbiter.sv
// Round-robin arbiter that shares a 4-digit 7-segment display between sources A and B.
// One-edge latency from request to grant and data. A requester whose grant is pending waits for the owner's dwell time to expire.
module display_arbiter #(
   parameter int DWELL_CYCLES = 8,
   parameter int CNT_W        = 4,
   parameter bit BLANK_LZ     = 1'b1
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_ReqA,
   input  logic [15:0] i_DatosA,
   output logic        o_GntA,
   input  logic        i_ReqB,
   input  logic [15:0] i_DatosB,
   output logic        o_GntB,
   output logic [3:0]  o_Datos1,
   output logic [3:0]  o_Datos2,
   output logic [3:0]  o_Datos3,
   output logic [3:0]  o_Datos4,
   output logic [3:0]  o_Blank,
   output logic [1:0]  o_Owner
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OWN_A = 2'b01,
      OWN_B = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             last_b_q;
   logic             gnt_a_q, gnt_b_q;
   logic [15:0]      datos_q;
   logic [3:0]       blank_q;
   logic [1:0]       owner_q;
   logic             dwell_done;
   logic             entering;
   logic [15:0]      sel_dat;

   function automatic logic [3:0] blank_of(input logic [15:0] v);
      logic z4, z3, z2;
      z4 = (v[15:12] == 4'd0);
      z3 = z4 && (v[11:8] == 4'd0);
      z2 = z3 && (v[7:4] == 4'd0);
      return BLANK_LZ ? {z4, z3, z2, 1'b0} : 4'b0000;
   endfunction

   assign dwell_done = (cnt_q == DWELL_MAX);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (i_ReqA && i_ReqB)
               state_d = last_b_q ? OWN_A : OWN_B;
            else if (i_ReqA)
               state_d = OWN_A;
            else if (i_ReqB)
               state_d = OWN_B;
         end
         OWN_A: begin
            // Dropping the request always wins over the dwell guard.
            if (!i_ReqA)
               state_d = i_ReqB ? OWN_B : IDLE;
            else if (i_ReqB && dwell_done)
               state_d = OWN_B;
         end
         OWN_B: begin
            if (!i_ReqB)
               state_d = i_ReqA ? OWN_A : IDLE;
            else if (i_ReqA && dwell_done)
               state_d = OWN_A;
         end
         default: state_d = IDLE;
      endcase
   end

   assign entering = (state_d != state_q) && (state_d != IDLE);
   assign sel_dat  = (state_d == OWN_B) ? i_DatosB : i_DatosA;

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_b_q <= 1'b1;
         gnt_a_q  <= 1'b0;
         gnt_b_q  <= 1'b0;
         datos_q  <= 16'h0000;
         blank_q  <= 4'b1111;
         owner_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         gnt_a_q <= (state_d == OWN_A);
         gnt_b_q <= (state_d == OWN_B);
         owner_q <= state_d;

         if (entering) begin
            cnt_q    <= '0;
            last_b_q <= (state_d == OWN_B);
         end else if (state_q != IDLE && !dwell_done) begin
            cnt_q <= cnt_q + 1'b1;
         end

         // In IDLE the digits freeze on the last owner's value and are fully blanked.
         if (state_d == IDLE) begin
            blank_q <= 4'b1111;
         end else begin
            datos_q <= sel_dat;
            blank_q <= blank_of(sel_dat);
         end
      end
   end

   assign o_GntA   = gnt_a_q;
   assign o_GntB   = gnt_b_q;
   assign o_Owner  = owner_q;
   assign o_Blank  = blank_q;
   assign o_Datos1 = datos_q[3:0];
   assign o_Datos2 = datos_q[7:4];
   assign o_Datos3 = datos_q[11:8];
   assign o_Datos4 = datos_q[15:12];

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized and directed checks of display_arbiter against a cycle-level reference model.
module tb_display_arbiter;

   localparam int DWELL = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_a = 1'b0, req_b = 1'b0;
   logic [15:0] dat_a = 16'h0, dat_b = 16'h0;
   logic        gnt_a, gnt_b;
   logic [3:0]  d1, d2, d3, d4, blank;
   logic [1:0]  owner;

   int vectors = 0;
   int miscompares = 0;

   // reference model: owner 0=none 1=A 2=B
   int          m_owner, m_held, m_last;
   logic [15:0] m_dat;
   logic [3:0]  m_blank;

   display_arbiter #(.DWELL_CYCLES(DWELL), .CNT_W(4), .BLANK_LZ(1'b1)) dut (
      .i_Clk(clk), .i_Rst(rst_n),
      .i_ReqA(req_a), .i_DatosA(dat_a), .o_GntA(gnt_a),
      .i_ReqB(req_b), .i_DatosB(dat_b), .o_GntB(gnt_b),
      .o_Datos1(d1), .o_Datos2(d2), .o_Datos3(d3), .o_Datos4(d4),
      .o_Blank(blank), .o_Owner(owner)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] lz_mask(input logic [15:0] v);
      int z;
      logic [3:0] m;
      z = 0;
      for (int i = 3; i >= 1; i--) begin
         if (((v >> (4 * i)) & 16'hF) == 16'h0) z++;
         else break;
      end
      m = 4'b0000;
      for (int k = 0; k < z; k++) m[3-k] = 1'b1;
      return m;
   endfunction

   function automatic logic [23:0] exp_vec();
      return {m_owner == 1, m_owner == 2, 2'(m_owner), m_dat, m_blank};
   endfunction

   function automatic logic [23:0] obs_vec();
      return {gnt_a, gnt_b, owner, d4, d3, d2, d1, blank};
   endfunction

   task automatic model_reset();
      m_owner = 0; m_held = 0; m_last = 2; m_dat = 16'h0; m_blank = 4'hF;
   endtask

   task automatic model_update();
      int nxt;
      bit done;
      nxt  = m_owner;
      done = (m_held >= DWELL - 1);
      if (m_owner == 0) begin
         if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
         else if (req_a)     nxt = 1;
         else if (req_b)     nxt = 2;
      end else begin
         bit mine, other;
         mine  = (m_owner == 1) ? req_a : req_b;
         other = (m_owner == 1) ? req_b : req_a;
         if (!mine)              nxt = other ? 3 - m_owner : 0;
         else if (other && done) nxt = 3 - m_owner;
      end
      if (nxt != 0 && nxt != m_owner) begin
         m_held = 0; m_last = nxt;
      end else if (nxt != 0) begin
         m_held++;
      end
      m_owner = nxt;
      if (nxt == 1) m_dat = dat_a;
      else if (nxt == 2) m_dat = dat_b;
      m_blank = (nxt == 0) ? 4'hF : lz_mask(m_dat);
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_a = 1'b1; dat_a = 16'h1234;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({gnt_a, gnt_b, owner, blank} !== {1'b0, 1'b0, 2'b00, 4'b1111}) begin
         miscompares++;
         $display("FAIL reset_state: got gnt=%b%b owner=%b blank=%b, want 00 00 1111", gnt_a, gnt_b, owner, blank);
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if ({gnt_a, owner, d4, d3, d2, d1, blank} !== {1'b1, 2'b01, 16'h1234, 4'b0000}) begin
         miscompares++;
         $display("FAIL first_grant: got gntA=%b owner=%b dat=%h%h%h%h blank=%b", gnt_a, owner, d4, d3, d2, d1, blank);
      end
   endtask

   task automatic test_lz_blank();
      logic [15:0] vals [4] = '{16'h0975, 16'h0001, 16'h0000, 16'h00F0};
      logic [3:0]  exps [4] = '{4'b1000, 4'b1110, 4'b1110, 4'b1100};
      for (int i = 0; i < 4; i++) begin
         dat_a = vals[i];
         tick();
         vectors++;
         if ({d4, d3, d2, d1, blank} !== {vals[i], exps[i]}) begin
            miscompares++;
            $display("FAIL lz_blank[%0d]: got dat=%h%h%h%h blank=%b, want %h %b", i, d4, d3, d2, d1, blank, vals[i], exps[i]);
         end
      end
   endtask

   task automatic test_release_idle();
      dat_a = 16'h4321; req_b = 1'b0;
      repeat (3) tick();
      req_a = 1'b0; dat_a = 16'h9999;
      tick();
      vectors++;
      if ({gnt_a, gnt_b, owner, d4, d3, d2, d1, blank} !== {2'b00, 2'b00, 16'h4321, 4'b1111}) begin
         miscompares++;
         $display("FAIL release_idle: got gnt=%b%b owner=%b dat=%h%h%h%h blank=%b", gnt_a, gnt_b, owner, d4, d3, d2, d1, blank);
      end
   endtask

   task automatic test_tie();
      dat_b = 16'hBEEF;
      req_a = 1'b1; req_b = 1'b1;
      tick();
      vectors++;
      if ({gnt_a, gnt_b, owner} !== {2'b01, 2'b10}) begin
         miscompares++;
         $display("FAIL tie_b_first: got gnt=%b%b owner=%b, want 01 10", gnt_a, gnt_b, owner);
      end
      req_b = 1'b0;
      tick();
      vectors++;
      if ({gnt_a, gnt_b, owner} !== {2'b10, 2'b01}) begin
         miscompares++;
         $display("FAIL tie_handover: got gnt=%b%b owner=%b, want 10 01", gnt_a, gnt_b, owner);
      end
   endtask

   task automatic test_dwell_preempt();
      int a_cycles;
      bit prev_a, switched;
      req_a = 1'b0; req_b = 1'b0;
      tick();
      req_a = 1'b1;
      tick();
      a_cycles = gnt_a ? 1 : 0;
      prev_a = gnt_a;
      switched = 1'b0;
      req_b = 1'b1;
      for (int i = 0; i < 40 && !switched; i++) begin
         tick();
         vectors++;
         if (gnt_a && gnt_b) begin
            miscompares++;
            $display("FAIL grant_overlap: both grants high at cycle %0d", i);
         end
         if (gnt_a) a_cycles++;
         if (gnt_b) begin
            switched = 1'b1;
            vectors++;
            if (prev_a !== 1'b1) begin
               miscompares++;
               $display("FAIL no_idle_switch: got previous gntA=%b, want 1", prev_a);
            end
         end
         prev_a = gnt_a;
      end
      vectors++;
      if (!switched || a_cycles != DWELL) begin
         miscompares++;
         $display("FAIL dwell_len: got switched=%0d a_cycles=%0d, want 1 %0d", switched, a_cycles, DWELL);
      end
   endtask

   task automatic test_async_reset();
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({gnt_a, gnt_b, owner, blank} !== {2'b00, 2'b00, 4'b1111}) begin
         miscompares++;
         $display("FAIL async_reset: got gnt=%b%b owner=%b blank=%b, want 00 00 1111", gnt_a, gnt_b, owner, blank);
      end
      model_reset();
      #2 rst_n = 1'b1;
      tick();
      vectors++;
      if ({gnt_a, gnt_b, owner} !== {2'b10, 2'b01}) begin
         miscompares++;
         $display("FAIL post_reset_a_first: got gnt=%b%b owner=%b, want 10 01", gnt_a, gnt_b, owner);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) req_a = ~req_a;
         if ($urandom_range(0, 9) == 0) req_b = ~req_b;
         dat_a = 16'($urandom) >> (4 * $urandom_range(0, 4));
         dat_b = 16'($urandom) >> (4 * $urandom_range(0, 4));
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL random[%0d]: got %h, want %h", i, obs_vec(), exp_vec());
         end
         if ($urandom_range(0, 99) == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
            model_reset();
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lz_blank();
      test_release_idle();
      test_tie();
      test_dwell_preempt();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the 4-digit multiplexed 7-segment display between two independent data sources, A and B.
- Each source requests the display with a req/gnt handshake. The arbiter grants one source at a time using round-robin. A granted source keeps the display for a minimum dwell time before it can be preempted.
- Outputs feed the display controller's four 4-bit digit inputs directly, plus a per-digit blank mask.

Parameters:
- DWELL_CYCLES, 8, minimum clock cycles an owner keeps the grant before the other requester may preempt (must be >= 2).
- CNT_W, 4, dwell counter width (must satisfy 2**CNT_W > DWELL_CYCLES).
- BLANK_LZ, 1, 1 = blank leading-zero digits of the granted value; 0 = never blank digits while granted.

Ports:
- i_Clk  input  1  system clock, all state updates on rising edge.
- i_Rst  input  1  asynchronous, active-low reset.
- i_ReqA  input  1  source A requests the display (level, held while it wants it).
- i_DatosA  input  16  source A value, 4 BCD/hex nibbles; [3:0] = digit 1 (rightmost).
- o_GntA  output  1  A owns the display.
- i_ReqB  input  1  source B request.
- i_DatosB  input  16  source B value.
- o_GntB  output  1  B owns the display.
- o_Datos1..o_Datos4  output  4 each  digit nibbles to the display controller (Datos1 = rightmost).
- o_Blank  output  4  per-digit blank, bit i blanks o_Datos(i+1).
- o_Owner  output  2  00 = none, 01 = A, 10 = B.

Behaviour:
- Reset (i_Rst = 0, asynchronous):
  - state = IDLE, o_GntA = o_GntB = 0, o_Datos1..4 = 0, o_Blank = 4'b1111, o_Owner = 00.
  - Dwell counter = 0; last-served pointer = B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B. o_GntA = (state == OWN_A), o_GntB = (state == OWN_B). Both grants are never high in the same cycle.
- All outputs are registered. A request sampled high at edge n gives a grant visible after edge n. The owner's data is loaded on that same edge, so grant and data appear together.
- IDLE:
  - only ReqA -> OWN_A; only ReqB -> OWN_B.
  - both -> the source not last served.
  - none -> stay in IDLE; o_Blank = 1111; o_Datos hold their last values.
- OWN_X: every edge, o_Datos1..4 <= i_DatosX nibbles (live tracking), and o_Blank is recomputed from the new value.
- Dwell counter:
  - Cleared to 0 on every edge that enters OWN_A or OWN_B, including a direct A<->B switch.
  - Increments once per edge while the owner is unchanged and saturates at DWELL_CYCLES-1.
  - dwell_done = (counter == DWELL_CYCLES-1).
- Transitions out of OWN_X, in priority order:
  - ReqX low -> release immediately, regardless of dwell. Go to OWN_Y if ReqY is high, else IDLE.
  - ReqX high, ReqY high, dwell_done -> OWN_Y. This is a direct switch with no idle cycle.
  - Otherwise stay in OWN_X.
- Last-served pointer: updated to X on entry to OWN_X.
- Leading-zero blanking (BLANK_LZ = 1, while granted):
  - Blank digit 4 if its nibble is 0.
  - Blank digit 3 if it and all digits above it are 0; same rule for digit 2.
  - Digit 1 is never blanked, so value 0 shows "0": o_Blank = 1110.
- BLANK_LZ = 0: o_Blank = 0000 while granted.
- Boundary conditions:
  - Requests arriving the same cycle as a release: the other source is granted on that edge.
  - A requester that drops its request and re-raises it while the other is requesting loses the round-robin tie.
  - Reset asserted mid-ownership: grants drop asynchronously with no glitch on the other grant.
  - Reset release: first grant occurs on the first edge with i_Rst = 1 and a request sampled high.

Test Plan:
- Reset held, ReqA = 1 -> o_GntA = 0, o_Blank = 1111, o_Owner = 00. Release reset -> after edge 1: o_GntA = 1, o_Owner = 01, o_Datos = i_DatosA nibbles.
- ReqA only, DatosA = 16'h0975 -> o_Datos4..1 = 0,9,7,5; o_Blank = 1000. Change DatosA to 16'h0001 -> next edge o_Blank = 1110.
- A owning, ReqB raised 1 cycle after grant, ReqA held -> GntA stays high for exactly 8 cycles from grant, then GntB = 1 on the next edge, with no overlap and no idle cycle.
- From IDLE, ReqA and ReqB rise together after A was last served -> B granted first. After B drops its request -> A granted on the same edge.
- A owning 3 cycles, ReqA drops, ReqB low -> IDLE next edge: o_Blank = 1111, o_Datos hold their values, o_Owner = 00.
- Reset asserted asynchronously mid-OWN_B -> o_GntB falls immediately, not on a clock edge. With both requests still high at reset release, A is granted first.
